// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM write channel and one RAM read channel between
// two requesters. Each channel has its own round-robin arbiter.
// Writes issue at most every second cycle. A read issues a single strobe,
// waits READ_LAT cycles for ReadData, captures it, and then pulses rd_valid
// to the requester that owns the read. A read to the address of a write that
// issues in the same cycle is held back until a later cycle, so it returns
// the new data. All outputs are registered. Reset is synchronous.
module ram_arbiter #(
   parameter int ADDR_W   = 4,
   parameter int DATA_W   = 8,
   parameter int READ_LAT = 1    // cycles from read strobe to ReadData valid, 1..3
) (
   input  logic                  clock,
   input  logic                  reset,
   // client side
   input  logic [1:0]            req_wr,
   input  logic [2*ADDR_W-1:0]   wr_addr,
   input  logic [2*DATA_W-1:0]   wr_data,
   input  logic [1:0]            req_rd,
   input  logic [2*ADDR_W-1:0]   rd_addr,
   output logic [1:0]            wr_gnt,
   output logic [1:0]            rd_gnt,
   output logic [1:0]            rd_valid,
   output logic [DATA_W-1:0]     rd_data,
   // RAM side
   input  logic                  WriteReady,
   input  logic                  ReadReady,
   output logic                  write,
   output logic                  read,
   output logic [ADDR_W-1:0]     WriteAddr,
   output logic [DATA_W-1:0]     WriteData,
   output logic [ADDR_W-1:0]     ReadAddr,
   input  logic [DATA_W-1:0]     ReadData
);

   // Two bits hold the largest supported latency (3).
   localparam int               CNT_W    = 2;
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LAT);

   typedef enum logic {
      W_IDLE,
      W_HOLD
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_DONE
   } rd_state_t;

   // The single requester wins. If both request, the favoured one wins.
   function automatic logic pick_winner(input logic [1:0] req, input logic favour);
      logic win;
      case (req)
         2'b01:   win = 1'b0;
         2'b10:   win = 1'b1;
         default: win = favour;
      endcase
      return win;
   endfunction

   function automatic logic [1:0] one_hot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

   wr_state_t          wr_state, wr_state_n;
   rd_state_t          rd_state, rd_state_n;

   // Each channel favours the requester it did not grant last.
   logic               wr_favour;
   logic               rd_favour;

   logic               wr_win;
   logic               rd_win;
   logic [ADDR_W-1:0]  wr_win_addr;
   logic [DATA_W-1:0]  wr_win_data;
   logic [ADDR_W-1:0]  rd_win_addr;

   logic               wr_issue;
   logic               rd_issue;
   logic               rd_capture;
   logic               rd_hazard;

   logic               rd_owner;
   logic [CNT_W-1:0]   rd_cnt;

   // Winner selection and extraction of the winner's slice on each channel.
   always_comb begin
      wr_win      = pick_winner(req_wr, wr_favour);
      rd_win      = pick_winner(req_rd, rd_favour);
      wr_win_addr = wr_win ? wr_addr[2*ADDR_W-1:ADDR_W] : wr_addr[ADDR_W-1:0];
      wr_win_data = wr_win ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0];
      rd_win_addr = rd_win ? rd_addr[2*ADDR_W-1:ADDR_W] : rd_addr[ADDR_W-1:0];
   end

   // Write FSM next state. A write issues from IDLE and then rests one cycle.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no
      // path through the case leaves a value unassigned and infers a latch.
      wr_state_n = wr_state;
      wr_issue   = 1'b0;
      case (wr_state)
         W_IDLE: begin
            if (WriteReady && (req_wr != 2'b00)) begin
               wr_issue   = 1'b1;
               wr_state_n = W_HOLD;
            end
         end
         W_HOLD:  wr_state_n = W_IDLE;
         default: wr_state_n = W_IDLE;
      endcase
   end

   // Read FSM next state. The hazard check holds back a read whose address
   // matches a write issuing in the same cycle.
   always_comb begin
      rd_hazard  = wr_issue && (rd_win_addr == wr_win_addr);
      rd_state_n = rd_state;
      rd_issue   = 1'b0;
      rd_capture = 1'b0;
      case (rd_state)
         R_IDLE: begin
            if (ReadReady && (req_rd != 2'b00) && !rd_hazard) begin
               rd_issue   = 1'b1;
               rd_state_n = R_WAIT;
            end
         end
         R_WAIT: begin
            if (rd_cnt == '0) begin
               rd_capture = 1'b1;
               rd_state_n = R_DONE;
            end
         end
         R_DONE:  rd_state_n = R_IDLE;
         default: rd_state_n = R_IDLE;
      endcase
   end

   // State registers for both FSMs.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments, so every register
      // samples values from before the edge, whatever the statement order.
      if (!reset) begin
         wr_state <= W_IDLE;
         rd_state <= R_IDLE;
      end else begin
         wr_state <= wr_state_n;
         rd_state <= rd_state_n;
      end
   end

   // Write datapath: strobe, grant, held address/data and the round-robin pointer.
   always_ff @(posedge clock) begin
      if (!reset) begin
         write     <= 1'b0;
         wr_gnt    <= 2'b00;
         WriteAddr <= '0;
         WriteData <= '0;
         wr_favour <= 1'b0;
      end else begin
         write  <= wr_issue;
         wr_gnt <= wr_issue ? one_hot(wr_win) : 2'b00;
         if (wr_issue) begin
            WriteAddr <= wr_win_addr;
            WriteData <= wr_win_data;
            wr_favour <= ~wr_win;
         end
      end
   end

   // Read datapath: strobe, grant, owner, latency counter, capture and valid.
   always_ff @(posedge clock) begin
      if (!reset) begin
         read      <= 1'b0;
         rd_gnt    <= 2'b00;
         ReadAddr  <= '0;
         rd_owner  <= 1'b0;
         rd_cnt    <= '0;
         rd_favour <= 1'b0;
         rd_valid  <= 2'b00;
         rd_data   <= '0;
      end else begin
         read   <= rd_issue;
         rd_gnt <= rd_issue ? one_hot(rd_win) : 2'b00;
         if (rd_issue) begin
            ReadAddr  <= rd_win_addr;
            rd_owner  <= rd_win;
            rd_cnt    <= LAT_LOAD;
            rd_favour <= ~rd_win;
         end else if ((rd_state == R_WAIT) && (rd_cnt != '0)) begin
            rd_cnt <= rd_cnt - CNT_W'(1);
         end
         rd_valid <= rd_capture ? one_hot(rd_owner) : 2'b00;
         if (rd_capture) begin
            rd_data <= ReadData;
         end
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: drives ram_arbiter against a small RAM model and compares
// every output, every cycle, with a transaction-level reference. The reference
// tracks the earliest cycle each channel can issue again, the last winner per
// channel, a golden memory image and the cycle when each read result is due.
module tb_ram_arbiter;

   localparam int ADDR_W   = 4;
   localparam int DATA_W   = 8;
   localparam int READ_LAT = 1;
   localparam int DEPTH    = 2**ADDR_W;

   logic                clock = 1'b0;
   logic                reset;
   logic [1:0]          req_wr;
   logic [2*ADDR_W-1:0] wr_addr;
   logic [2*DATA_W-1:0] wr_data;
   logic [1:0]          req_rd;
   logic [2*ADDR_W-1:0] rd_addr;
   logic [1:0]          wr_gnt, rd_gnt, rd_valid;
   logic [DATA_W-1:0]   rd_data;
   logic                WriteReady, ReadReady;
   logic                write, read;
   logic [ADDR_W-1:0]   WriteAddr, ReadAddr;
   logic [DATA_W-1:0]   WriteData, ReadData;

   ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
      .clock(clock), .reset(reset),
      .req_wr(req_wr), .wr_addr(wr_addr), .wr_data(wr_data),
      .req_rd(req_rd), .rd_addr(rd_addr),
      .wr_gnt(wr_gnt), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
      .WriteReady(WriteReady), .ReadReady(ReadReady),
      .write(write), .read(read),
      .WriteAddr(WriteAddr), .WriteData(WriteData), .ReadAddr(ReadAddr),
      .ReadData(ReadData)
   );

   always #5 clock = ~clock;

   // RAM stand-in: writes land on the edge after the strobe, and read data
   // appears READ_LAT cycles after the read strobe.
   logic [DATA_W-1:0] ram   [DEPTH]    = '{default: '0};
   logic [DATA_W-1:0] rpipe [READ_LAT] = '{default: '0};
   always @(posedge clock) begin
      if (write) ram[WriteAddr] <= WriteData;
      for (int i = READ_LAT - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
      if (read) rpipe[0] <= ram[ReadAddr];
   end
   assign ReadData = rpipe[READ_LAT-1];

   // Reference state.
   int                cyc = 0;
   int                n_checks = 0;
   int                n_pass = 0;
   int                wr_next_ok, rd_next_ok;
   logic              wr_last, rd_last;
   int                rv_edge;
   logic              rv_owner;
   logic [DATA_W-1:0] rv_data;
   logic [DATA_W-1:0] gmem [DEPTH] = '{default: '0};
   // Expected outputs for the cycle after the coming edge.
   logic              x_write, x_read;
   logic [1:0]        x_wr_gnt, x_rd_gnt, x_rd_valid;
   logic [ADDR_W-1:0] x_waddr, x_raddr;
   logic [DATA_W-1:0] x_wdata, x_rdata;
   // Grants seen in the current cycle, used to drive the requesters.
   logic [1:0]        w_granted, r_granted;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
   endtask

   function automatic logic [ADDR_W-1:0] rand_addr();
      // A few hot addresses plus the top one, so that collisions are common.
      if ($urandom_range(0, 4) == 0) return '1;
      return ADDR_W'($urandom_range(0, 3));
   endfunction

   // Compute what the next edge should produce, advance one cycle and compare.
   task automatic step();
      logic              w_go, r_go, w_win, r_win;
      logic [ADDR_W-1:0] w_a, r_a;
      logic [DATA_W-1:0] w_d;
      cyc++;
      x_write = 1'b0; x_read = 1'b0;
      x_wr_gnt = 2'b00; x_rd_gnt = 2'b00; x_rd_valid = 2'b00;
      if (!reset) begin
         wr_next_ok = 0; rd_next_ok = 0;
         wr_last = 1'b1; rd_last = 1'b1;
         rv_edge = -1;
         x_waddr = '0; x_wdata = '0; x_raddr = '0; x_rdata = '0;
      end else begin
         if (rv_edge == cyc) begin
            x_rd_valid = rv_owner ? 2'b10 : 2'b01;
            x_rdata    = rv_data;
            rv_edge    = -1;
         end
         w_win = (req_wr == 2'b11) ? ~wr_last : req_wr[1];
         w_a   = wr_addr[int'(w_win)*ADDR_W +: ADDR_W];
         w_d   = wr_data[int'(w_win)*DATA_W +: DATA_W];
         w_go  = (cyc >= wr_next_ok) && WriteReady && (req_wr != 2'b00);
         r_win = (req_rd == 2'b11) ? ~rd_last : req_rd[1];
         r_a   = rd_addr[int'(r_win)*ADDR_W +: ADDR_W];
         r_go  = (cyc >= rd_next_ok) && ReadReady && (req_rd != 2'b00)
                 && !(w_go && (w_a == r_a));
         if (r_go) begin
            x_read     = 1'b1;
            x_rd_gnt   = r_win ? 2'b10 : 2'b01;
            x_raddr    = r_a;
            rd_last    = r_win;
            rv_owner   = r_win;
            rv_data    = gmem[r_a];
            rv_edge    = cyc + READ_LAT + 1;
            rd_next_ok = cyc + READ_LAT + 3;
         end
         if (w_go) begin
            x_write    = 1'b1;
            x_wr_gnt   = w_win ? 2'b10 : 2'b01;
            x_waddr    = w_a;
            x_wdata    = w_d;
            wr_last    = w_win;
            gmem[w_a]  = w_d;
            wr_next_ok = cyc + 2;
         end
      end
      @(posedge clock);
      #1;
      check("write",     write,     x_write);
      check("wr_gnt",    wr_gnt,    x_wr_gnt);
      check("WriteAddr", WriteAddr, x_waddr);
      check("WriteData", WriteData, x_wdata);
      check("read",      read,      x_read);
      check("rd_gnt",    rd_gnt,    x_rd_gnt);
      check("ReadAddr",  ReadAddr,  x_raddr);
      check("rd_valid",  rd_valid,  x_rd_valid);
      check("rd_data",   rd_data,   x_rdata);
      w_granted = x_wr_gnt;
      r_granted = x_rd_gnt;
   endtask

   task automatic idle(input int n);
      req_wr = 2'b00;
      req_rd = 2'b00;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      reset = 1'b0;
      req_wr = '0; wr_addr = '0; wr_data = '0;
      req_rd = '0; rd_addr = '0;
      WriteReady = 1'b1; ReadReady = 1'b1;

      // Reset, then ten quiet cycles with no requests.
      for (int i = 0; i < 3; i++) step();
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("quiet_write", write, 1'b0);
         check("quiet_read",  read,  1'b0);
      end

      // Single write from requester 0.
      req_wr = 2'b01; wr_addr[3:0] = 4'd3; wr_data[7:0] = 8'hA5;
      step();
      check("w1_write", write, 1'b1);
      check("w1_gnt",   wr_gnt, 2'b01);
      check("w1_addr",  WriteAddr, 4'd3);
      check("w1_data",  WriteData, 8'hA5);
      req_wr = 2'b00;
      step();
      check("w1_drop", write, 1'b0);

      // Both write requests held: grants alternate starting from requester 0.
      reset = 1'b0; step(); reset = 1'b1;
      req_wr = 2'b11;
      wr_addr = {4'd2, 4'd1}; wr_data = {8'h22, 8'h11};
      for (int i = 0; i < 6; i++) begin
         step();
         case (i)
            0, 4:    check("rr_gnt", wr_gnt, 2'b01);
            2:       check("rr_gnt", wr_gnt, 2'b10);
            default: check("rr_gnt", wr_gnt, 2'b00);
         endcase
      end
      idle(2);

      // Requester 1 reads back address 3.
      req_rd = 2'b10; rd_addr[7:4] = 4'd3;
      step();
      check("r1_gnt",  rd_gnt, 2'b10);
      check("r1_read", read, 1'b1);
      req_rd = 2'b00;
      step();
      step();
      check("r1_valid", rd_valid, 2'b10);
      check("r1_data",  rd_data, 8'hA5);
      idle(4);

      // Write and read of address 7 requested together: the read waits.
      req_wr = 2'b01; wr_addr[3:0] = 4'd7; wr_data[7:0] = 8'h3C;
      req_rd = 2'b01; rd_addr[3:0] = 4'd7;
      step();
      check("haz_write", write, 1'b1);
      check("haz_held",  read, 1'b0);
      req_wr = 2'b00;
      step();
      check("haz_issue", rd_gnt, 2'b01);
      req_rd = 2'b00;
      seen = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
         step();
         if (rd_valid != 2'b00) begin
            seen = 1'b1;
            check("haz_data", rd_data, 8'h3C);
         end
      end
      check("haz_valid_seen", seen, 1'b1);
      idle(4);

      // Reset while a read waits for data: the read is dropped silently.
      req_rd = 2'b01; rd_addr[3:0] = 4'd3;
      step();
      check("rst_gnt", rd_gnt, 2'b01);
      req_rd = 2'b00;
      reset = 1'b0;
      step();
      check("rst_read",  read, 1'b0);
      check("rst_rdgnt", rd_gnt, 2'b00);
      check("rst_valid", rd_valid, 2'b00);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("rst_no_valid", rd_valid, 2'b00);
      end
      req_rd = 2'b10; rd_addr[7:4] = 4'd3;
      step();
      check("post_gnt", rd_gnt, 2'b10);
      req_rd = 2'b00;
      step();
      step();
      check("post_valid", rd_valid, 2'b10);
      check("post_data",  rd_data, 8'hA5);

      // Randomized traffic under the reference.
      for (int k = 0; k < 3000; k++) begin
         for (int n = 0; n < 2; n++) begin
            if (w_granted[n] || (req_wr[n] && $urandom_range(0, 39) == 0)) begin
               req_wr[n] = w_granted[n] && ($urandom_range(0, 1) == 1);
               wr_addr[n*ADDR_W +: ADDR_W] = rand_addr();
               wr_data[n*DATA_W +: DATA_W] = DATA_W'($urandom);
            end else if (!req_wr[n] && $urandom_range(0, 2) == 0) begin
               req_wr[n] = 1'b1;
               wr_addr[n*ADDR_W +: ADDR_W] = rand_addr();
               wr_data[n*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
            if (r_granted[n] || (req_rd[n] && $urandom_range(0, 39) == 0)) begin
               req_rd[n] = r_granted[n] && ($urandom_range(0, 1) == 1);
               rd_addr[n*ADDR_W +: ADDR_W] = rand_addr();
            end else if (!req_rd[n] && $urandom_range(0, 2) == 0) begin
               req_rd[n] = 1'b1;
               rd_addr[n*ADDR_W +: ADDR_W] = rand_addr();
            end
         end
         WriteReady = ($urandom_range(0, 3) != 0);
         ReadReady  = ($urandom_range(0, 3) != 0);
         reset      = ($urandom_range(0, 299) != 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single 16x8 RAM write and read channels between two requesters (0 and 1).
- Write and read channels arbitrate independently, each round-robin.
- Sequences the RAM handshake (WriteReady/ReadReady in, single-cycle write/read pulses out) and returns read data, tagged to the owning requester, after a fixed latency.
- Sits between client logic and the RAM instance, replacing direct client drive of the RAM ports.

Parameters:
ADDR_W, 4, RAM address width
DATA_W, 8, RAM data width
READ_LAT, 1, cycles from read pulse to ReadData valid (1..3)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
req_wr  in  2  write request per requester, level, held until granted
wr_addr  in  2*ADDR_W  write address; requester n at [n*ADDR_W +: ADDR_W]
wr_data  in  2*DATA_W  write data, packed as wr_addr
req_rd  in  2  read request per requester, level, held until granted
rd_addr  in  2*ADDR_W  read address, packed as wr_addr
wr_gnt  out  2  one-hot pulse: requester's write issued this cycle
rd_gnt  out  2  one-hot pulse: requester's read issued this cycle
rd_valid  out  2  one-hot pulse: rd_data belongs to that requester
rd_data  out  DATA_W  captured read data
WriteReady  in  1  RAM can accept a write
ReadReady  in  1  RAM can accept a read
write  out  1  RAM write strobe, 1 cycle
read  out  1  RAM read strobe, 1 cycle
WriteAddr  out  ADDR_W  RAM write address
WriteData  out  DATA_W  RAM write data
ReadAddr  out  ADDR_W  RAM read address
ReadData  in  DATA_W  RAM read data

Behaviour:
- Reset (reset==0 at clock edge): every output is 0; both FSMs go to IDLE; both round-robin pointers favour requester 0; latency counter is cleared; any in-flight read is discarded with no rd_valid.

Write FSM (IDLE, HOLD):
- IDLE, with WriteReady=1 and req_wr!=0:
  - Select the winner.
  - Register WriteAddr/WriteData from the winner's slice.
  - Drive write=1 and wr_gnt[winner]=1 in the same cycle.
  - Go to HOLD.
- HOLD: write=0 and wr_gnt=0 for one cycle, then IDLE. Peak rate is one write per 2 cycles.
- WriteAddr/WriteData hold their last issued values between writes.

Read FSM (IDLE, WAIT, DONE):
- IDLE, with ReadReady=1, req_rd!=0 and no hazard:
  - Register ReadAddr.
  - Drive read=1 and rd_gnt[winner]=1.
  - Latch the owner.
  - Load the counter with READ_LAT.
  - Go to WAIT.
- WAIT: decrement the counter. When it reaches 0, sample ReadData into rd_data and go to DONE.
- DONE: rd_valid[owner]=1 for exactly one cycle, then IDLE. rd_data holds until the next capture.
- With READ_LAT=1, rd_valid asserts 2 cycles after the read pulse.

Arbitration:
- One requester active: it wins.
- Both active: the requester not granted last on that channel wins; the pointer then flips.
- The pointer updates only on a grant.

Hazard:
- A read is withheld (stays in IDLE, no rd_gnt) if its selected address equals the address of a write issuing in the same cycle.
- The read issues on a later cycle, so it returns the new data.

Boundaries:
- WriteReady or ReadReady low: no issue; requests wait indefinitely, with no timeout.
- A request dropped before grant is simply not served.
- A request still held after its gnt is treated as a new request. Requesters must drop or update it on the gnt cycle.
- Address 15 is handled like any other; no wrap logic is needed.

Test Plan:
- Release reset with no requests -> all outputs 0 for 10 cycles; write and read never assert.
- req_wr=01, wr_addr0=3, wr_data0=8'hA5, WriteReady=1 -> write=1, WriteAddr=3, WriteData=A5 and wr_gnt=01 in the same cycle; write=0 next cycle.
- req_wr=11 held 6 cycles, WriteReady=1 -> grants alternate 01,10,01 on cycles 0,2,4.
- req_rd=10, rd_addr1=3 after the A5 write, READ_LAT=1 -> rd_gnt=10 with read=1; 2 cycles later rd_valid=10 and rd_data=A5.
- Write to address 7 and read from address 7 requested in the same cycle (old content 00, new 3C) -> read withheld that cycle; later rd_data=3C.
- Assert reset in WAIT -> no rd_valid; read=0 and rd_gnt=0; after release the next read sequences normally.
